// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns pc_F, runs the imem request/grant/response handshake
// and holds the IF/ID register plus a one-entry skid buffer. Option: FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   input  logic                  stall_D,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  valid_D,
   output logic [31:0]           instr_D,
   output logic [ADDR_WIDTH-1:0] pc_D,
   output logic [ADDR_WIDTH-1:0] pc_plus4_D,
   output logic                  misalign,
   output logic [1:0]            state_dbg
);

   localparam logic [31:0]           NOP     = 32'h0000_0013;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc_f;
   logic [ADDR_WIDTH-1:0] pc_f_seq;
   logic [ADDR_WIDTH-1:0] skid_pc;
   logic [31:0]           skid_instr;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  redirect_bad;
   logic                  misalign_q;
   logic                  gnt_taken;
   logic                  can_load;

   // Handshake: a request is accepted in any cycle where imem_req && imem_gnt; exactly one
   // imem_rvalid follows in a later cycle, and no new request is raised until it has arrived.
`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect_target = redirect_pc;
   assign redirect_bad    = |redirect_pc[1:0];
`else
   assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
   assign redirect_bad    = 1'b0;
`endif

   assign pc_f_seq  = pc_f + PC_STEP;
   assign imem_req  = (state == S_REQ) && !misalign_q;
   assign imem_addr = pc_f;
   assign gnt_taken = imem_req && imem_gnt;
   assign can_load  = !valid_D || !stall_D;
   assign state_dbg = state;
   assign misalign  = misalign_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc_f       <= RESET_PC;
         valid_D    <= 1'b0;
         instr_D    <= NOP;
         pc_D       <= '0;
         pc_plus4_D <= '0;
         skid_instr <= NOP;
         skid_pc    <= '0;
         misalign_q <= 1'b0;
      end else if (redirect) begin
         // Flush decode; an already-granted request still owes a response, so drain it.
         pc_f       <= redirect_target;
         valid_D    <= 1'b0;
         instr_D    <= NOP;
         skid_instr <= NOP;
         skid_pc    <= '0;
         misalign_q <= redirect_bad;
         case (state)
            S_REQ:   state <= gnt_taken ? S_DRAIN : S_REQ;
            S_WAIT:  state <= imem_rvalid ? S_REQ : S_DRAIN;
            S_HOLD:  state <= S_REQ;
            S_DRAIN: state <= imem_rvalid ? S_REQ : S_DRAIN;
            default: state <= S_REQ;
         endcase
      end else begin
         // Decode consumes the current instruction unless something new is loaded below.
         if (!stall_D) begin
            valid_D <= 1'b0;
            instr_D <= NOP;
         end
         case (state)
            S_REQ: begin
               if (gnt_taken) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (can_load) begin
                     valid_D    <= 1'b1;
                     instr_D    <= imem_rdata;
                     pc_D       <= pc_f;
                     pc_plus4_D <= pc_f_seq;
                     pc_f       <= pc_f_seq;
                     state      <= S_REQ;
                  end else begin
                     skid_instr <= imem_rdata;
                     skid_pc    <= pc_f;
                     state      <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_D) begin
                  valid_D    <= 1'b1;
                  instr_D    <= skid_instr;
                  pc_D       <= skid_pc;
                  pc_plus4_D <= skid_pc + PC_STEP;
                  pc_f       <= pc_f_seq;
                  state      <= S_REQ;
               end
            end
            S_DRAIN: begin
               if (imem_rvalid) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-memory responder
// (grant one cycle after a request is seen, response rsp_lat cycles after grant).
module tb_fetch_stage;

   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] XMASK   = 32'hA5A5_0000;
   localparam logic [1:0]  S_REQ   = 2'd0;
   localparam logic [1:0]  S_WAIT  = 2'd1;
   localparam logic [1:0]  S_HOLD  = 2'd2;
   localparam logic [1:0]  S_DRAIN = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        stall_D = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        valid_D;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc_plus4_D;
   logic        misalign;
   logic [1:0]  state_dbg;

   int          n_vec = 0;
   int          n_err = 0;

   // memory responder state
   logic        req_prev = 1'b0;
   logic [31:0] rsp_addr = '0;
   int          rsp_cnt  = 0;
   int          rsp_lat  = 1;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall_D     (stall_D),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .valid_D     (valid_D),
      .instr_D     (instr_D),
      .pc_D        (pc_D),
      .pc_plus4_D  (pc_plus4_D),
      .misalign    (misalign),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   // Advance one clock, then drive this cycle's memory-side inputs.
   task automatic cycle();
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rsp_addr ^ XMASK;
         end
      end
      imem_gnt = imem_req && req_prev && !rst;
      if (imem_gnt) begin
         rsp_addr = imem_addr;
         rsp_cnt  = rsp_lat;
      end
      req_prev = imem_req && !imem_gnt;
   endtask

   task automatic do_reset();
      stall_D     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      rsp_cnt     = 0;
      rsp_lat     = 1;
      rst         = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rsp_cnt     = 0;
      rst         = 1'b1;
      stall_D     = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      cycle();
      cycle();
      n_vec++; if (state_dbg !== S_REQ) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_REQ); end
      n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b want 1", imem_req); end
      n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
      n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_D); end
      n_vec++; if (instr_D !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", instr_D, NOP); end
      n_vec++; if (pc_D !== 32'h0 || pc_plus4_D !== 32'h0) begin n_err++; $display("FAIL reset_pc_d: got %h/%h want 0/0", pc_D, pc_plus4_D); end
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign); end
      stall_D  = 1'b0;
      redirect = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_fetch_sequence();
      logic [31:0] exp_pc;
      do_reset();
      for (int c = 0; c <= 12; c++) begin
         if (c != 0) cycle();
         if (c == 2) begin
            n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL seq_early_valid: got %b want 0", valid_D); end
         end
         if (c == 4) begin
            n_vec++; if (valid_D !== 1'b0 || pc_D !== 32'h0) begin n_err++; $display("FAIL seq_consume: got v=%b pc=%h want v=0 pc=00000000", valid_D, pc_D); end
         end
         if (c == 3 || c == 6 || c == 9 || c == 12) begin
            exp_pc = 32'((c / 3 - 1) * 4);
            n_vec++; if (valid_D !== 1'b1 || pc_D !== exp_pc) begin n_err++; $display("FAIL seq_pc c%0d: got v=%b pc=%h want v=1 pc=%h", c, valid_D, pc_D, exp_pc); end
            n_vec++; if (instr_D !== (exp_pc ^ XMASK)) begin n_err++; $display("FAIL seq_instr c%0d: got %h want %h", c, instr_D, exp_pc ^ XMASK); end
            n_vec++; if (pc_plus4_D !== exp_pc + 32'd4) begin n_err++; $display("FAIL seq_pc4 c%0d: got %h want %h", c, pc_plus4_D, exp_pc + 32'd4); end
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         if (c != 0) cycle();
         stall_D = (c >= 6 && c <= 9);
         if (c == 9) begin
            n_vec++; if (state_dbg !== S_HOLD) begin n_err++; $display("FAIL stall_hold_state: got %0d want %0d", state_dbg, S_HOLD); end
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h4) begin n_err++; $display("FAIL stall_hold_d: got v=%b pc=%h want v=1 pc=00000004", valid_D, pc_D); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_hold_req: got %b want 0", imem_req); end
         end
         if (c == 10) begin
            n_vec++; if (state_dbg !== S_HOLD || pc_D !== 32'h4) begin n_err++; $display("FAIL stall_last: got st=%0d pc=%h want st=2 pc=00000004", state_dbg, pc_D); end
         end
         if (c == 11) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h8 || instr_D !== 32'hA5A5_0008) begin n_err++; $display("FAIL stall_release: got v=%b pc=%h i=%h want v=1 pc=00000008 i=a5a50008", valid_D, pc_D, instr_D); end
            n_vec++; if (imem_addr !== 32'hC || state_dbg !== S_REQ) begin n_err++; $display("FAIL stall_next_addr: got a=%h st=%0d want a=0000000c st=0", imem_addr, state_dbg); end
         end
         if (c == 12) begin
            n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL stall_no_dup: got %b want 0", valid_D); end
         end
         if (c == 14) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'hC || instr_D !== 32'hA5A5_000C) begin n_err++; $display("FAIL stall_after: got v=%b pc=%h i=%h want v=1 pc=0000000c i=a5a5000c", valid_D, pc_D, instr_D); end
         end
      end
      stall_D = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      rsp_lat = 2;
      for (int c = 0; c <= 8; c++) begin
         if (c != 0) cycle();
         redirect    = (c == 2);
         redirect_pc = 32'h100;
         if (c == 2) begin
            n_vec++; if (state_dbg !== S_WAIT) begin n_err++; $display("FAIL rdw_wait: got %0d want %0d", state_dbg, S_WAIT); end
         end
         if (c == 3) begin
            n_vec++; if (state_dbg !== S_DRAIN || imem_req !== 1'b0 || valid_D !== 1'b0) begin n_err++; $display("FAIL rdw_drain: got st=%0d req=%b v=%b want st=3 req=0 v=0", state_dbg, imem_req, valid_D); end
         end
         if (c == 4) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_D !== 1'b0) begin n_err++; $display("FAIL rdw_newreq: got req=%b a=%h v=%b want req=1 a=00000100 v=0", imem_req, imem_addr, valid_D); end
         end
         if (c == 7) begin
            n_vec++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rdw_quiet: got %b want 0", valid_D); end
         end
         if (c == 8) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h100 || instr_D !== 32'hA5A5_0100) begin n_err++; $display("FAIL rdw_target: got v=%b pc=%h i=%h want v=1 pc=00000100 i=a5a50100", valid_D, pc_D, instr_D); end
         end
      end
      redirect = 1'b0;
      rsp_lat  = 1;
   endtask

   task automatic test_redirect_rvalid_stall();
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         if (c != 0) cycle();
         stall_D     = (c >= 3 && c <= 5);
         redirect    = (c == 5);
         redirect_pc = 32'h40;
         if (c == 5) begin
            n_vec++; if (state_dbg !== S_WAIT || valid_D !== 1'b1 || pc_D !== 32'h0) begin n_err++; $display("FAIL rrs_pre: got st=%0d v=%b pc=%h want st=1 v=1 pc=00000000", state_dbg, valid_D, pc_D); end
         end
         if (c == 6) begin
            n_vec++; if (valid_D !== 1'b0 || instr_D !== NOP) begin n_err++; $display("FAIL rrs_flush: got v=%b i=%h want v=0 i=%h", valid_D, instr_D, NOP); end
            n_vec++; if (state_dbg !== S_REQ || imem_addr !== 32'h40) begin n_err++; $display("FAIL rrs_addr: got st=%0d a=%h want st=0 a=00000040", state_dbg, imem_addr); end
         end
         if (c == 9) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h40 || instr_D !== 32'hA5A5_0040) begin n_err++; $display("FAIL rrs_target: got v=%b pc=%h i=%h want v=1 pc=00000040 i=a5a50040", valid_D, pc_D, instr_D); end
         end
      end
      stall_D  = 1'b0;
      redirect = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c <= 3; c++) begin
         if (c != 0) cycle();
         redirect    = (c == 0);
         redirect_pc = 32'hFFFF_FFFC;
         if (c == 1) begin
            n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req_addr: got %h want fffffffc", imem_addr); end
         end
         if (c == 3) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'hFFFF_FFFC || instr_D !== 32'h5A5A_FFFC) begin n_err++; $display("FAIL wrap_d: got v=%b pc=%h i=%h want v=1 pc=fffffffc i=5a5afffc", valid_D, pc_D, instr_D); end
            n_vec++; if (pc_plus4_D !== 32'h0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got p4=%h a=%h want 0/0", pc_plus4_D, imem_addr); end
         end
      end
      redirect = 1'b0;
   endtask

   task automatic test_misalign();
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         if (c != 0) cycle();
         redirect    = (c == 0 || c == 2);
         redirect_pc = (c == 0) ? 32'h102 : 32'h200;
`ifdef FETCH_MISALIGN_CHECK_EN
         if (c == 1) begin
            n_vec++; if (misalign !== 1'b1 || imem_req !== 1'b0 || state_dbg !== S_REQ) begin n_err++; $display("FAIL mis_set: got m=%b req=%b st=%0d want m=1 req=0 st=0", misalign, imem_req, state_dbg); end
         end
         if (c == 2) begin
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mis_parked: got %b want 0", imem_req); end
         end
`else
         if (c == 1) begin
            n_vec++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL mis_forced: got m=%b req=%b a=%h want m=0 req=1 a=00000100", misalign, imem_req, imem_addr); end
         end
`endif
         if (c == 3) begin
            n_vec++; if (misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL mis_clear: got m=%b req=%b a=%h want m=0 req=1 a=00000200", misalign, imem_req, imem_addr); end
         end
         if (c == 6) begin
            n_vec++; if (valid_D !== 1'b1 || pc_D !== 32'h200 || instr_D !== 32'hA5A5_0200) begin n_err++; $display("FAIL mis_resume: got v=%b pc=%h i=%h want v=1 pc=00000200 i=a5a50200", valid_D, pc_D, instr_D); end
         end
      end
      redirect = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch_sequence();
      test_stall();
      test_redirect_wait();
      test_redirect_rvalid_stall();
      test_wrap();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
